// File: rtl/clk_tick_scheduler_pkg.sv
// Shared types and constants for clk_tick_scheduler.
// The WAIT state is only reachable when CLKDIV_WRAP_SYNC_EN is defined.
package clk_tick_pkg;

    localparam int unsigned CHAN_W          = 3;
    localparam int unsigned RST_DIV_DEFAULT = 262143;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/clk_tick_scheduler_channel.sv
// tick_channel: one divider slice (counter, divisor, enable, tick, square wave).
// CLKDIV_WRAP_SYNC_EN adds a divisor load that lands on the counter boundary.
module tick_channel
    import clk_tick_pkg::*;
#(
    parameter int unsigned   CW      = 19,
    parameter logic [CW-1:0] RST_DIV = CW'(RST_DIV_DEFAULT),
    parameter logic          RST_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
`ifdef CLKDIV_WRAP_SYNC_EN
    input  logic          sync_load,
    output logic          at_wrap,
    output logic          en_now,
`endif
    input  logic [CW-1:0] new_div,
    input  logic          new_en,
    output logic          tick,
    output logic          sq
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic          en;
    logic          wrap;

    assign wrap = en && (cnt == div);

`ifdef CLKDIV_WRAP_SYNC_EN
    assign at_wrap = wrap;
    assign en_now  = en;
`endif

    // A load takes priority over the boundary, so no tick escapes on an apply cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            div  <= RST_DIV;
            en   <= RST_EN;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            div  <= new_div;
            en   <= new_en;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
`ifdef CLKDIV_WRAP_SYNC_EN
            if (sync_load) begin
                div <= new_div;
            end
`endif
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_tick_scheduler.sv
// clk_tick_scheduler: NCH clock-enable tick / square-wave generators with a config FSM.
// Define CLKDIV_WRAP_SYNC_EN for boundary-synchronous divisor changes (WAIT state).
module clk_tick_scheduler
    import clk_tick_pkg::*;
#(
    parameter int unsigned    NCH     = 4,
    parameter int unsigned    CW      = 19,
    parameter logic [CW-1:0]  RST_DIV = CW'(RST_DIV_DEFAULT),
    parameter logic [NCH-1:0] RST_EN  = NCH'(4'b0001)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [CW-1:0]     cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    sq,
    output logic [CHAN_W-1:0] busy_chan
);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  lat_div;
    logic           lat_en;
    logic           xfer;
    logic           chan_ok;
    logic [NCH-1:0] tgt_sel;
    logic [NCH-1:0] load_vec;
`ifdef CLKDIV_WRAP_SYNC_EN
    logic [NCH-1:0] req_sel;
    logic [NCH-1:0] sync_vec;
    logic [NCH-1:0] wrap_vec;
    logic [NCH-1:0] en_vec;
    logic           req_en;
    logic           tgt_wrap;
`endif

    assign xfer    = cfg_valid && cfg_ready;
    assign chan_ok = 32'(cfg_chan) < NCH;

    // busy_chan doubles as the latched target index for the APPLY/WAIT cycle.
    always_comb begin
        tgt_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            tgt_sel[i] = (32'(busy_chan) == i);
        end
    end

`ifdef CLKDIV_WRAP_SYNC_EN
    always_comb begin
        req_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            req_sel[i] = (32'(cfg_chan) == i);
        end
    end

    assign req_en   = |(req_sel & en_vec);
    assign tgt_wrap = |(tgt_sel & wrap_vec);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_div   <= '0;
            lat_en    <= 1'b0;
            busy_chan <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= xfer && !chan_ok;
            if (xfer && chan_ok) begin
                lat_div   <= cfg_div;
                lat_en    <= cfg_en;
                busy_chan <= cfg_chan;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (xfer && chan_ok) begin
`ifdef CLKDIV_WRAP_SYNC_EN
                    state_nx = (cfg_en && req_en) ? WAIT : APPLY;
`else
                    state_nx = APPLY;
`endif
                end
            end
            APPLY: state_nx = IDLE;
`ifdef CLKDIV_WRAP_SYNC_EN
            WAIT: begin
                if (tgt_wrap) begin
                    state_nx = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == IDLE);
        load_vec  = (state == APPLY) ? tgt_sel : '0;
`ifdef CLKDIV_WRAP_SYNC_EN
        sync_vec  = (state == WAIT) ? tgt_sel : '0;
`endif
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .CW      (CW),
            .RST_DIV (RST_DIV),
            .RST_EN  (RST_EN[g])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[g]),
`ifdef CLKDIV_WRAP_SYNC_EN
            .sync_load (sync_vec[g]),
            .at_wrap   (wrap_vec[g]),
            .en_now    (en_vec[g]),
`endif
            .new_div   (lat_div),
            .new_en    (lat_en),
            .tick      (tick[g]),
            .sq        (sq[g])
        );
    end

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Self-checking bench for clk_tick_scheduler; ch0 reset divisor shortened to 5.
// Wrap-sync sequence is compiled only when CLKDIV_WRAP_SYNC_EN is defined.
module tb_clk_tick_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 19;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_chan;
    logic [CW-1:0] cfg_div;
    logic          cfg_en;
    logic          cfg_err;
    logic [3:0]    tick;
    logic [3:0]    sq;
    logic [2:0]    busy_chan;

    int checks = 0;
    int errors = 0;

    clk_tick_scheduler #(
        .NCH     (NCH),
        .CW      (CW),
        .RST_DIV (19'd5),
        .RST_EN  (4'b0001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq),
        .busy_chan (busy_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [2:0]    chan;
        logic [CW-1:0] div;
        logic          en;
        logic [3:0]    etick;
        logic [3:0]    esq;
        logic          eready;
        logic          eerr;
        logic [2:0]    ebusy;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic v, input logic [2:0] c, input logic [CW-1:0] d,
                                input logic e, input logic [3:0] t, input logic [3:0] s,
                                input logic r, input logic er, input logic [2:0] b);
        vec_t x;
        x.valid  = v;
        x.chan   = c;
        x.div    = d;
        x.en     = e;
        x.etick  = t;
        x.esq    = s;
        x.eready = r;
        x.eerr   = er;
        x.ebusy  = b;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] c, input logic [CW-1:0] d, input logic e);
        cfg_valid = 1'b1;
        cfg_chan  = c;
        cfg_div   = d;
        cfg_en    = e;
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " tick"}, 32'(tick), 32'd0);
        check({tag, " sq"}, 32'(sq), 32'd0);
        check({tag, " ready"}, 32'(cfg_ready), 32'd1);
        check({tag, " err"}, 32'(cfg_err), 32'd0);
        check({tag, " busy"}, 32'(busy_chan), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        cfg_chan = '0;
        cfg_div  = '0;
        cfg_en   = 1'b0;
        repeat (3) step();
        check_reset_state("reset");
        rst = 1'b1;
    endtask

    initial begin
        // Row k drives inputs for edge k after reset release; expectations follow that edge.
        vecs[0]  = mk(0, 3'd0, 19'd0, 0, 4'b0000, 4'b0000, 1, 0, 3'd0);
        vecs[1]  = mk(1, 3'd1, 19'd3, 1, 4'b0000, 4'b0000, 0, 0, 3'd1);
        vecs[2]  = mk(1, 3'd2, 19'd0, 1, 4'b0000, 4'b0000, 1, 0, 3'd1);
        vecs[3]  = mk(1, 3'd5, 19'd7, 1, 4'b0000, 4'b0000, 1, 1, 3'd1);
        vecs[4]  = mk(0, 3'd0, 19'd0, 0, 4'b0000, 4'b0000, 1, 0, 3'd1);
        vecs[5]  = mk(1, 3'd2, 19'd0, 1, 4'b0001, 4'b0001, 0, 0, 3'd2);
        vecs[6]  = mk(0, 3'd0, 19'd0, 0, 4'b0010, 4'b0011, 1, 0, 3'd2);
        vecs[7]  = mk(0, 3'd0, 19'd0, 0, 4'b0100, 4'b0111, 1, 0, 3'd2);
        vecs[8]  = mk(0, 3'd0, 19'd0, 0, 4'b0100, 4'b0011, 1, 0, 3'd2);
        vecs[9]  = mk(1, 3'd2, 19'd0, 0, 4'b0100, 4'b0111, 0, 0, 3'd2);
        vecs[10] = mk(0, 3'd0, 19'd0, 0, 4'b0010, 4'b0001, 1, 0, 3'd2);
        vecs[11] = mk(0, 3'd0, 19'd0, 0, 4'b0001, 4'b0000, 1, 0, 3'd2);
        vecs[12] = mk(0, 3'd0, 19'd0, 0, 4'b0000, 4'b0000, 1, 0, 3'd2);
        vecs[13] = mk(0, 3'd0, 19'd0, 0, 4'b0000, 4'b0000, 1, 0, 3'd2);
        vecs[14] = mk(0, 3'd0, 19'd0, 0, 4'b0010, 4'b0010, 1, 0, 3'd2);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            cfg_valid = vecs[i].valid;
            cfg_chan  = vecs[i].chan;
            cfg_div   = vecs[i].div;
            cfg_en    = vecs[i].en;
            step();
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].etick));
            check($sformatf("vec%0d sq", i), 32'(sq), 32'(vecs[i].esq));
            check($sformatf("vec%0d ready", i), 32'(cfg_ready), 32'(vecs[i].eready));
            check($sformatf("vec%0d err", i), 32'(cfg_err), 32'(vecs[i].eerr));
            if (!vecs[i].eready) begin
                check($sformatf("vec%0d busy", i), 32'(busy_chan), 32'(vecs[i].ebusy));
            end
        end
        idle();

        // Reset while APPLY is pending: request dropped, ch0 restarts from zero.
        do_reset();
        req(3'd3, 19'd2, 1'b1);
        step();
        check("A ready", 32'(cfg_ready), 32'd0);
        check("A busy", 32'(busy_chan), 32'd3);
        idle();
        rst = 1'b0;
        step();
        check_reset_state("A rst");
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("A e%0d tick3", k), 32'(tick[3]), 32'd0);
            check($sformatf("A e%0d sq3", k), 32'(sq[3]), 32'd0);
            check($sformatf("A e%0d tick0", k), 32'(tick[0]), 32'(k == 6));
        end

`ifndef CLKDIV_WRAP_SYNC_EN
        // Rewrite of the same values lands on the boundary cycle: apply wins, channel restarts.
        do_reset();
        req(3'd1, 19'd3, 1'b1);
        step();
        check("B ready", 32'(cfg_ready), 32'd0);
        idle();
        for (int e = 2; e <= 8; e++) begin
            step();
            check($sformatf("B e%0d tick1", e), 32'(tick[1]), 32'(e == 6));
            if (e == 2) check("B ready back", 32'(cfg_ready), 32'd1);
            if (e == 6) check("B sq1", 32'(sq[1]), 32'd1);
        end
        req(3'd1, 19'd3, 1'b1);
        step();
        check("B e9 ready", 32'(cfg_ready), 32'd0);
        check("B e9 tick1", 32'(tick[1]), 32'd0);
        idle();
        step();
        check("B e10 tick1", 32'(tick[1]), 32'd0);
        check("B e10 sq1", 32'(sq[1]), 32'd0);
        check("B e10 ready", 32'(cfg_ready), 32'd1);
        for (int e = 11; e <= 14; e++) begin
            step();
            check($sformatf("B e%0d tick1", e), 32'(tick[1]), 32'(e == 14));
            if (e == 12) check("B e12 tick0", 32'(tick[0]), 32'd1);
        end
        check("B e14 sq1", 32'(sq[1]), 32'd1);
`else
        // Divisor change on a running channel waits for the old boundary; sq is not cleared.
        do_reset();
        req(3'd1, 19'd9, 1'b1);
        step();
        idle();
        step();
        step();
        req(3'd1, 19'd4, 1'b1);
        step();
        check("C e4 ready", 32'(cfg_ready), 32'd0);
        idle();
        for (int e = 5; e <= 11; e++) begin
            step();
            check($sformatf("C e%0d ready", e), 32'(cfg_ready), 32'd0);
            check($sformatf("C e%0d tick1", e), 32'(tick[1]), 32'd0);
        end
        step();
        check("C e12 tick1", 32'(tick[1]), 32'd1);
        check("C e12 sq1", 32'(sq[1]), 32'd1);
        check("C e12 ready", 32'(cfg_ready), 32'd1);
        for (int e = 13; e <= 22; e++) begin
            step();
            check($sformatf("C e%0d tick1", e), 32'(tick[1]), 32'((e == 17) || (e == 22)));
            if (e == 17) check("C e17 sq1", 32'(sq[1]), 32'd0);
            if (e == 22) check("C e22 sq1", 32'(sq[1]), 32'd1);
        end
        req(3'd1, 19'd7, 1'b1);
        step();
        check("C e23 ready", 32'(cfg_ready), 32'd0);
        idle();
        rst = 1'b0;
        step();
        check_reset_state("C rst");
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("C post e%0d tick1", k), 32'(tick[1]), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_tick_scheduler.md
Name: clk_tick_scheduler

Overview:
- Synchronous replacement and controller for the board's divided clocks. Generates NCH independent clock-enable ticks and square waves from the single system clock, with no ripple or derived clocks.
- A single config port sets each channel's divisor and enable, sequenced by a small FSM.
- Sits between the top-level clock and the slow consumers (LED blinkers, debouncers, display multiplexers), which use tick as a clock enable.

Parameters:
- NCH, 4, number of channels (1..8).
- CW, 19, counter/divisor width in bits.
- RST_DIV, 262143, divisor loaded into every channel at reset. 2^18-1 gives an sq period of 2^19 clk.
- RST_EN, 4'b0001, per-channel enable mask at reset (NCH bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  FSM can accept a request.
- cfg_chan  in  3  target channel index.
- cfg_div  in  CW  new divisor D.
- cfg_en  in  1  new channel enable.
- cfg_err  out  1  one-cycle pulse when an accepted request names cfg_chan >= NCH.
- tick  out  NCH  one-cycle enable pulse per channel.
- sq  out  NCH  50%-ish square wave per channel; toggles on each tick.
- busy_chan  out  3  channel being applied (valid when cfg_ready=0).

Behaviour:
- Reset (rst=0 at edge):
  - cnt=0, div=RST_DIV, en=RST_EN for every channel.
  - tick=0, sq=0, cfg_ready=1, cfg_err=0, busy_chan=0, FSM=IDLE.
  - Reset overrides everything, including mid-APPLY/WAIT; any pending request is dropped.
- Channel counting (each channel independent):
  - en=1, cnt==div: cnt<=0, tick<=1, sq<=~sq.
  - en=1, otherwise: cnt<=cnt+1, tick<=0.
  - Result: tick is high exactly one cycle in every D+1. Its first pulse is D+1 cycles after the enable/apply edge.
  - D=0: tick constantly 1 and sq toggles every cycle.
  - cnt never exceeds div. No wrap of cnt past 2^CW-1 is possible because cnt resets at div.
  - en=0: cnt held 0, tick=0, sq forced 0.
- Handshake: a transfer occurs on a clk edge with cfg_valid && cfg_ready. Inputs are sampled only then. cfg_valid while cfg_ready=0 is ignored; no queueing.
- FSM states: IDLE, APPLY, plus WAIT only when the macro is defined.
  - IDLE: cfg_ready=1.
    - On a transfer with cfg_chan < NCH: latch chan/div/en, set busy_chan, go to APPLY (or WAIT, see Optional Feature).
    - On a transfer with cfg_chan >= NCH: cfg_err=1 next cycle, stay in IDLE, no channel is changed.
  - APPLY: cfg_ready=0, one cycle.
    - Target channel: div<=latched div, en<=latched en, cnt<=0, tick<=0, sq<=0.
    - Return to IDLE.
    - If the target is at cnt==div in this cycle, the apply wins: no tick is emitted.
  - Throughput: one request per 2 cycles. Non-target channels are never disturbed.
- Same values rewritten: still restarts the channel (cnt=0, sq=0).

Optional Feature:
- Macro: CLKDIV_WRAP_SYNC_EN.
- Defined: a transfer targeting a channel that is currently enabled, with cfg_en=1, goes IDLE->WAIT.
  - WAIT holds cfg_ready=0 until the target's cnt==div cycle.
  - On that edge the normal tick and sq toggle occur, and the new div takes effect with cnt<=0 and sq not cleared. This gives a glitch-free period change.
  - Then back to IDLE. Maximum WAIT duration is old D+1 cycles.
  - All other transfers (target disabled, or cfg_en=0) use APPLY as in the base behaviour.
- Undefined: the WAIT state is absent and every valid transfer goes through APPLY.

Decomposition:
- Package clk_tick_pkg: FSM state enum (IDLE, APPLY, WAIT); localparam for the cfg_chan width (3); RST_DIV default constant.
- Sub-module tick_channel (one counter/div/en/tick/sq slice with load/hold inputs), instantiated NCH times via generate. The FSM stays in the top.

Test Plan:
- Reset then release, no config -> ch0 tick every 262144 cycles, sq[0] period 524288; ch1-3 tick=0, sq=0.
- Write ch1 D=3 en=1 -> cfg_ready low exactly 1 cycle; tick[1] every 4 cycles, first pulse 4 cycles after apply; ch0 phase unchanged.
- Write ch2 D=0 en=1, then ch2 en=0 -> tick[2] held 1 continuously; after disable, tick[2]=0 and sq[2]=0 from the apply edge.
- cfg_chan=5 with valid -> cfg_err single pulse, no tick/sq change, cfg_ready back to 1 the next cycle; cfg_valid during APPLY is not accepted.
- rst=0 asserted while in APPLY/WAIT -> all outputs at reset values on the next edge; the pending request is lost.
- CLKDIV_WRAP_SYNC_EN: ch1 running D=9, write D=4 at cnt=2 -> cfg_ready low 8 cycles, tick at the old boundary, sq not cleared, then period 5.
